// File: rtl/sic_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : sic_dispatch_queue
// Description : In-order circular packet queue between the issue controller
//               and the SIC array. Hands the head packet to one requesting
//               SIC per cycle (round-robin, with a one-cycle cooldown on the
//               last winner) and supports a whole-queue flush.
//               Optional macro SIC_DISPATCH_BYPASS_EN adds a same-cycle
//               bypass from in_pkt to the SICs when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sic_dispatch_queue #(
    parameter int NUM_SIC = 4,
    parameter int DEPTH   = 8,
    parameter int PKT_W   = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PKT_W-1:0]             in_pkt,
    input  logic                         flush,
    input  logic [NUM_SIC-1:0]           sic_req,
    output logic [NUM_SIC-1:0]           sic_pkt_valid,
    output logic [PKT_W-1:0]             sic_pkt,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int RR_W  = $clog2(NUM_SIC);
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
    localparam logic [RR_W-1:0]  RR_LAST  = RR_W'(NUM_SIC - 1);

    logic [PKT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [RR_W-1:0]    rr_q, rr_d;
    logic [NUM_SIC-1:0] cool_q, cool_d;

    logic               full, empty;
    logic [NUM_SIC-1:0] eligible;
    logic               found;
    logic [RR_W-1:0]    winner;
    logic [NUM_SIC-1:0] win_onehot;
    logic               push, store, pop_q, bypass, dispatch;

    assign full      = (occ_q == FULL_LVL);
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;

    // A full queue stalls even when it pops this cycle: readiness is kept
    // independent of the dispatch path to keep the timing path short.
    assign in_ready  = !rst && !flush && !full;
    assign push      = in_valid && in_ready;
    assign eligible  = sic_req & ~cool_q;

    // Round-robin scan upward from rr_q, wrapping modulo NUM_SIC.
    always_comb begin
        logic [RR_W-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_SIC; i++) begin
            cand = RR_W'((int'(rr_q) + i) % NUM_SIC);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign win_onehot = NUM_SIC'(1) << winner;
    assign pop_q      = !empty && !flush && !rst && found;

`ifdef SIC_DISPATCH_BYPASS_EN
    // Empty queue: an accepted packet may go straight to the winning SIC.
    assign bypass = empty && push && found;
`else
    assign bypass = 1'b0;
`endif

    assign dispatch      = pop_q || bypass;
    assign store         = push && !bypass;
    assign sic_pkt_valid = dispatch ? win_onehot : '0;

    // Payload broadcast: bypass data, else head entry, else zero.
    always_comb begin
        sic_pkt = '0;
        if (rst) begin
            sic_pkt = '0;
        end else if (bypass) begin
            sic_pkt = in_pkt;
        end else if (!empty) begin
            sic_pkt = mem_q[head_q];
        end
    end

    // Next-state for pointers, occupancy, round-robin pointer and cooldown.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        rr_d   = rr_q;
        cool_d = cool_q;
        if (flush) begin
            // Flush empties the queue but keeps arbitration history.
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (pop_q) begin
                head_d = head_q + PTR_W'(1);
            end
            if (store) begin
                tail_d = tail_q + PTR_W'(1);
            end
            occ_d = occ_q + OCC_W'(store) - OCC_W'(pop_q);
            if (dispatch) begin
                rr_d   = (winner == RR_LAST) ? '0 : winner + RR_W'(1);
                cool_d = win_onehot;
            end else begin
                cool_d = '0;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            rr_q   <= '0;
            cool_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            rr_q   <= rr_d;
            cool_q <= cool_d;
        end
    end

    // Payload storage; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[tail_q] <= in_pkt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sic_dispatch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_sic_dispatch_queue
// Description : Self-checking bench for sic_dispatch_queue. A queue-based
//               reference model predicts every output each cycle; directed
//               sequences add literal expectations at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sic_dispatch_queue;

    localparam int NS = 4;
    localparam int DP = 8;
    localparam int PW = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pkt;
    logic          flush;
    logic [NS-1:0] sic_req;
    logic [NS-1:0] sic_pkt_valid;
    logic [PW-1:0] sic_pkt;
    logic [3:0]    occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 0;

    sic_dispatch_queue #(.NUM_SIC(NS), .DEPTH(DP), .PKT_W(PW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pkt        (in_pkt),
        .flush         (flush),
        .sic_req       (sic_req),
        .sic_pkt_valid (sic_pkt_valid),
        .sic_pkt       (sic_pkt),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [PW-1:0] mq[$];
    int            m_rr   = 0;
    logic [NS-1:0] m_cool = '0;
    logic [NS-1:0] prev_valid = '0;
    logic [PW-1:0] got5[$];

    always @(negedge clk) begin
        if (mon_on) begin
            logic [NS-1:0] elig;
            logic [NS-1:0] exp_valid;
            logic [PW-1:0] exp_pkt;
            bit found, ready, byp, pop, disp;
            int win, size;
            elig  = sic_req & ~m_cool;
            found = 0;
            win   = 0;
            for (int i = 0; i < NS; i++) begin
                int k;
                k = (m_rr + i) % NS;
                if (!found && elig[k]) begin
                    found = 1;
                    win   = k;
                end
            end
            size  = mq.size();
            ready = !rst && !flush && (size < DP);
            byp   = 0;
`ifdef SIC_DISPATCH_BYPASS_EN
            byp   = (size == 0) && in_valid && ready && found;
`endif
            pop   = !rst && !flush && (size > 0) && found;
            disp  = pop || byp;
            exp_valid = disp ? NS'(1 << win) : '0;
            exp_pkt   = rst ? '0 : (byp ? in_pkt : ((size > 0) ? mq[0] : '0));

            check("in_ready", in_ready, ready);
            check("sic_pkt_valid", sic_pkt_valid, exp_valid);
            check("sic_pkt", sic_pkt, exp_pkt);
            check("occupancy", occupancy, size);
            check("no_back_to_back", |(sic_pkt_valid & prev_valid), 0);
            prev_valid = sic_pkt_valid;
            if (|sic_pkt_valid && sic_pkt[PW-1:8] == 24'h000050) got5.push_back(sic_pkt);

            if (rst) begin
                mq.delete();
                m_rr   = 0;
                m_cool = '0;
            end else if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (disp) begin
                    m_rr   = (win + 1) % NS;
                    m_cool = NS'(1 << win);
                end else begin
                    m_cool = '0;
                end
                if (in_valid && ready && !byp) mq.push_back(in_pkt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int id;
        rst = 1'b1; in_valid = 1'b0; in_pkt = '0; flush = 1'b0; sic_req = '0;
        tick();
        mon_on = 1;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", sic_pkt_valid, 0);
        tick();
        rst = 1'b0;
        #2;
        check("post_rst_occ", occupancy, 0);
        check("post_rst_ready", in_ready, 1);
        tick();

        // Back-to-back pushes with all SICs requesting.
        sic_req = 4'b1111;
        in_valid = 1'b1; in_pkt = 32'h0000_0A01;
        tick();
        in_pkt = 32'h0000_0B02;
        #2;
        check("t1_a_valid", sic_pkt_valid, 4'b0001);
        check("t1_a_pkt", sic_pkt, 32'h0000_0A01);
        check("t1_a_occ", occupancy, 1);
        tick();
        in_pkt = 32'h0000_0C03;
        #2;
        check("t1_b_valid", sic_pkt_valid, 4'b0010);
        check("t1_b_pkt", sic_pkt, 32'h0000_0B02);
        tick();
        in_valid = 1'b0;
        #2;
        check("t1_c_valid", sic_pkt_valid, 4'b0100);
        check("t1_c_pkt", sic_pkt, 32'h0000_0C03);
        tick();

        // Fill to full, then drain through SIC0 only.
        sic_req = 4'b0000;
        for (int i = 0; i < DP; i++) begin
            in_valid = 1'b1; in_pkt = 32'h0000_0200 + PW'(i);
            tick();
        end
        in_valid = 1'b0;
        sic_req = 4'b0001;
        #2;
        check("t2_full_occ", occupancy, 8);
        check("t2_full_ready", in_ready, 0);
        check("t2_first_valid", sic_pkt_valid, 4'b0001);
        tick();
        #2;
        check("t2_occ7", occupancy, 7);
        check("t2_ready_back", in_ready, 1);
        check("t2_cooldown", sic_pkt_valid, 4'b0000);
        tick();
        #2;
        check("t2_second_pkt", sic_pkt, 32'h0000_0201);
        tick();
        #2;
        check("t2_occ6", occupancy, 6);
        sic_req = 4'b0010;
        for (int c = 0; c < 30 && occupancy != 0; c++) tick();
        check("t2_drained", occupancy, 0);
        sic_req = 4'b0000;
        tick();

        // Round-robin wrap with rr pointer at 2.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pkt = 32'h0000_0300 + PW'(i);
            tick();
        end
        in_valid = 1'b0;
        sic_req = 4'b1010;
        #2;
        check("t3_first", sic_pkt_valid, 4'b1000);
        tick();
        #2;
        check("t3_second", sic_pkt_valid, 4'b0010);
        check("t3_second_pkt", sic_pkt, 32'h0000_0301);
        tick();
        #2;
        check("t3_third", sic_pkt_valid, 4'b1000);
        tick();
        sic_req = 4'b0000;
        tick();

        // Flush with competing push and requests.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_pkt = 32'h0000_0400 + PW'(i);
            tick();
        end
        flush = 1'b1; in_pkt = 32'h0000_04FF; sic_req = 4'b1111;
        #2;
        check("t4_flush_valid", sic_pkt_valid, 0);
        check("t4_flush_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; sic_req = 4'b0000;
        #2;
        check("t4_occ0", occupancy, 0);
        check("t4_ready", in_ready, 1);
        tick();

        // Ordered delivery of 20 IDs through random requests and wrap.
        id = 0;
        for (int c = 0; c < 300 && id < 20; c++) begin
            in_valid = 1'b1; in_pkt = 32'h0000_5000 + PW'(id);
            sic_req = NS'($urandom_range(0, 15));
            #2;
            if (in_ready) id++;
            tick();
        end
        in_valid = 1'b0;
        sic_req = 4'b1111;
        for (int c = 0; c < 60 && occupancy != 0; c++) tick();
        tick();
        check("t5_count", got5.size(), 20);
        for (int i = 0; i < 20 && i < got5.size(); i++) check("t5_order", got5[i], 32'h0000_5000 + i);
        sic_req = 4'b0000;
        tick();

        // Push into empty queue with one requester.
        in_valid = 1'b1; in_pkt = 32'h0000_ABCD; sic_req = 4'b0100;
        #2;
`ifdef SIC_DISPATCH_BYPASS_EN
        check("t6_bypass_valid", sic_pkt_valid, 4'b0100);
        check("t6_bypass_pkt", sic_pkt, 32'h0000_ABCD);
        tick();
        in_valid = 1'b0;
        #2;
        check("t6_bypass_occ", occupancy, 0);
`else
        check("t6_same_cycle", sic_pkt_valid, 4'b0000);
        tick();
        in_valid = 1'b0;
        #2;
        check("t6_next_valid", sic_pkt_valid, 4'b0100);
        check("t6_next_pkt", sic_pkt, 32'h0000_ABCD);
`endif
        tick();
        sic_req = 4'b0000;
        tick();

        // Reset in the middle of operation.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pkt = 32'h0000_0700 + PW'(i);
            tick();
        end
        rst = 1'b1; sic_req = 4'b1111;
        #2;
        check("t7_rst_valid", sic_pkt_valid, 0);
        check("t7_rst_pkt", sic_pkt, 0);
        tick();
        rst = 1'b0; in_valid = 1'b0; sic_req = 4'b0000;
        #2;
        check("t7_occ0", occupancy, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sic_dispatch_queue.md
Name: sic_dispatch_queue

Overview:
- In-order packet buffer between the issue controller and the array of single-instruction controllers (SICs).
- Accepts issued packets through a valid/ready handshake and holds them in a circular FIFO.
- Hands the head packet to one requesting SIC per cycle, chosen by round-robin, using that SIC's req_instr / packet_in.valid handshake.
- Supports a whole-queue flush when the PC is redirected.

Parameters:
- NUM_SIC, 4, number of SICs served; valid range 2..16.
- DEPTH, 8, number of queue entries; power of two, at least 2.
- PKT_W, 128, width of a flattened SIC packet, excluding its valid bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  issue controller offers in_pkt.
- in_ready  output  1  queue accepts in_pkt this cycle.
- in_pkt  input  PKT_W  packet payload from issue.
- flush  input  1  discard all queued packets, from the PC-redirect path.
- sic_req  input  NUM_SIC  bit k is req_instr of SIC k.
- sic_pkt_valid  output  NUM_SIC  one-hot or zero; bit k is packet_in.valid for SIC k.
- sic_pkt  output  PKT_W  payload broadcast to all SICs; meaningful only where sic_pkt_valid is set.
- occupancy  output  $clog2(DEPTH+1)  current number of queued entries, registered.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Head and tail pointers, occupancy, round-robin pointer and cooldown mask all go to 0.
  - While rst is high: in_ready=0, sic_pkt_valid=0, sic_pkt=0.
- Storage: circular buffer of DEPTH entries. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. full = (occupancy==DEPTH); empty = (occupancy==0).
- Push rule: in_ready = !rst && !flush && !full. This is combinational and deliberately ignores a same-cycle pop, so a full queue stalls for one cycle even while it is popping. A push happens when in_valid && in_ready; the entry is written at tail and tail increments.
- Dispatch candidates: eligible[k] = sic_req[k] && !cool[k].
- Dispatch condition: dispatch occurs when !empty && !flush && !rst && |eligible.
- Winner selection: the first eligible index found scanning upward from rr_ptr, wrapping modulo NUM_SIC.
- Dispatch outputs (combinational in the same cycle):
  - sic_pkt_valid[winner]=1 and all other bits 0.
  - sic_pkt = head entry. When nothing is dispatched, sic_pkt = head entry if the queue is non-empty, otherwise 0.
- On a dispatch edge: head increments, rr_ptr becomes (winner+1) mod NUM_SIC, and cool is set to the one-hot of winner.
- On any edge without a dispatch, cool clears to 0. The cooldown masks a SIC whose req_instr is still high in the cycle after it accepts a packet, so no SIC receives two packets back to back.
- Packets are dispatched strictly in push order. Only one packet is dispatched per cycle.
- occupancy next value = occupancy + push - pop. A simultaneous push and pop leaves occupancy unchanged.
- Flush (registered effect):
  - head, tail and occupancy are cleared.
  - cool and rr_ptr are kept.
  - No push and no dispatch occur in the flush cycle.
  - in_ready returns on the next cycle.
- Latency: a packet pushed at cycle t can be dispatched no earlier than cycle t+1 (without the optional feature).
- Wrap-around: pointer wrap must not corrupt data; verify with at least 2*DEPTH pushes.
- Reset asserted mid-operation discards every queued packet; nothing is dispatched during reset.

Optional Feature:
- Macro: SIC_DISPATCH_BYPASS_EN.
- Defined: when the queue is empty, in_valid && in_ready, and an eligible SIC exists (no flush), in_pkt is dispatched in the same cycle.
  - sic_pkt = in_pkt, and winner selection is identical to the normal rule.
  - The packet is not written to the queue; tail and occupancy are unchanged.
  - rr_ptr and cool update as for a normal dispatch.
- Undefined: no bypass path exists; minimum push-to-dispatch latency is 1 cycle.

Test Plan:
- Reset, then push packets A, B, C at cycles 1-3 with sic_req=4'b1111 held → A to SIC0 at cycle 2, B to SIC1 at cycle 3, C to SIC2 at cycle 4; occupancy never exceeds 1; in_ready stays 1.
- sic_req=0, push 8 packets → occupancy=8 and in_ready=0 at cycle 9. Then raise sic_req=4'b0001 → SIC0 receives packets every other cycle (cooldown); occupancy drops to 7 then 6; in_ready=1 only after occupancy<8 is registered.
- Queue holds 3 packets, sic_req=4'b1010, rr_ptr=2 → first dispatch goes to SIC3, then SIC1 (wrap), then SIC3.
- Queue holds 5 packets; assert flush for one cycle together with in_valid=1 and sic_req=4'b1111 → no sic_pkt_valid and no push that cycle; occupancy=0 the next cycle; in_ready=1 the next cycle.
- Push 20 packets with IDs 0..19 against randomly toggled sic_req (DEPTH=8) → SICs receive the IDs in order 0..19 with no loss or duplication; no SIC is ever valid in two consecutive cycles.
- With SIC_DISPATCH_BYPASS_EN defined, empty queue, in_valid=1, in_pkt=0xABCD, sic_req=4'b0100 → sic_pkt_valid=4'b0100 and sic_pkt=0xABCD in the same cycle, and occupancy stays 0. Without the macro, the same stimulus dispatches one cycle later.
